// File: rtl/ula_pkg.sv
// ula_pkg: opcodes, sequencer states and counter width shared by the ALU sequencer.
package ula_pkg;
  localparam logic [2:0] OP_SOMA = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_MULT = 3'b010;
  localparam logic [2:0] OP_DIV  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_OR   = 3'b101;
  localparam logic [2:0] OP_XOR  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } estado_t;
endpackage

// File: rtl/contador_execucao.sv
// contador_execucao: loadable down-counter that stops at zero.
module contador_execucao
  import ula_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] valor,
  output logic [W-1:0] cnt,
  output logic         zero
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= valor;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign zero = cnt == '0;
endmodule

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: issues one operation to an external ALU, waits EXEC_CYCLES, holds the result until acked.
module ula_sequenciador
  import ula_pkg::*;
#(
  parameter int EXEC_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [2:0] operacao,
  input  logic       use_acc,
  input  logic       ack,
  input  logic       clr_erro,
  output logic [7:0] ula_a,
  output logic [7:0] ula_b,
  output logic [2:0] ula_op,
  input  logic [7:0] ula_resultado,
  input  logic       ula_overflow,
  input  logic       ula_zero,
  input  logic       ula_carry,
  input  logic       ula_erro,
  output logic       ready,
  output logic       valid,
  output logic [7:0] resultado,
  output logic       overflow,
  output logic       zero,
  output logic       carry_out,
  output logic       erro,
  output logic       erro_sticky
);
  localparam logic [CNT_W-1:0] CARGA = CNT_W'(EXEC_CYCLES - 1);
  estado_t estado, prox;
  logic [7:0] a_q, b_q, acc_q;
  logic [2:0] op_q;
  logic [CNT_W-1:0] cnt;
  logic cnt_zero, carregar, capturar;
  contador_execucao #(.W(CNT_W)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (carregar),
    .en   (estado == EXEC),
    .valor(CARGA),
    .cnt  (cnt),
    .zero (cnt_zero)
  );
  assign carregar = estado == IDLE && start;
  assign capturar = estado == EXEC && cnt_zero;
  assign ready = estado == IDLE;
  assign valid = estado == DONE;
  assign ula_a = a_q;
  assign ula_b = b_q;
  assign ula_op = op_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) estado <= IDLE;
    else estado <= prox;
  always_comb begin
    prox = estado;
    case (estado)
      IDLE:    prox = start ? EXEC : IDLE;
      EXEC:    prox = cnt_zero ? DONE : EXEC;
      DONE:    prox = ack ? IDLE : DONE;
      default: prox = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      a_q <= '0;
      b_q <= '0;
      op_q <= '0;
    end else if (carregar) begin
      a_q <= use_acc ? acc_q : op_a;
      b_q <= op_b;
      op_q <= operacao;
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      acc_q <= '0;
      resultado <= '0;
      overflow <= 1'b0;
      zero <= 1'b0;
      carry_out <= 1'b0;
      erro <= 1'b0;
    end else if (capturar) begin
      acc_q <= ula_resultado;
      resultado <= ula_resultado;
      overflow <= ula_overflow;
      zero <= ula_zero;
      carry_out <= ula_carry;
      erro <= ula_erro;
    end
  // A capture with ula_erro beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst)
    if (!rst) erro_sticky <= 1'b0;
    else erro_sticky <= (capturar && ula_erro) || (erro_sticky && !clr_erro);
endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: directed and random transactions against a behavioural ALU and sequencer model.
module tb_ula_sequenciador;
  import ula_pkg::*;
  localparam int EC = 2;
  logic clk = 1'b0, rst = 1'b0;
  logic start = 1'b0, use_acc = 1'b0, ack = 1'b0, clr_erro = 1'b0;
  logic [7:0] op_a = '0, op_b = '0;
  logic [2:0] operacao = '0;
  logic [7:0] ula_a, ula_b, ula_resultado, resultado;
  logic [2:0] ula_op;
  logic ula_overflow, ula_zero, ula_carry, ula_erro;
  logic ready, valid, overflow, zero, carry_out, erro, erro_sticky;
  int checks = 0, failures = 0;
  logic [7:0] acc_m = '0;
  logic sticky_m = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    logic [8:0] w;
    logic [15:0] p;
    logic [7:0] r;
    logic ov, c, e;
    w = '0; p = '0; r = '0; ov = 1'b0; c = 1'b0; e = 1'b0;
    case (op)
      OP_SOMA: begin w = a + b; r = w[7:0]; c = w[8]; ov = (a[7] == b[7]) && (r[7] != a[7]); end
      OP_SUB:  begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; ov = (a[7] != b[7]) && (r[7] != a[7]); end
      OP_MULT: begin p = a * b; r = p[7:0]; c = |p[15:8]; end
      OP_DIV:  if (b == 8'd0) e = 1'b1; else r = a / b;
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      default: r = ~a;
    endcase
    return {r, ov, r == 8'd0, c, e};
  endfunction

  assign {ula_resultado, ula_overflow, ula_zero, ula_carry, ula_erro} = alu(ula_a, ula_b, ula_op);

  ula_sequenciador #(.EXEC_CYCLES(EC)) dut (
    .clk(clk), .rst(rst), .start(start), .op_a(op_a), .op_b(op_b), .operacao(operacao),
    .use_acc(use_acc), .ack(ack), .clr_erro(clr_erro), .ula_a(ula_a), .ula_b(ula_b), .ula_op(ula_op),
    .ula_resultado(ula_resultado), .ula_overflow(ula_overflow), .ula_zero(ula_zero),
    .ula_carry(ula_carry), .ula_erro(ula_erro), .ready(ready), .valid(valid), .resultado(resultado),
    .overflow(overflow), .zero(zero), .carry_out(carry_out), .erro(erro), .erro_sticky(erro_sticky)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, input logic ua,
                        input int hold, input logic noise, input logic both, input logic clr_cap);
    logic [7:0] ea;
    logic [11:0] e;
    ea = ua ? acc_m : a;
    e = alu(ea, b, op);
    @(negedge clk);
    chk("ready_idle", 32'(ready), 1);
    start = 1'b1; op_a = a; op_b = b; operacao = op; use_acc = ua;
    @(negedge clk);
    start = 1'b0;
    chk("ula_a", 32'(ula_a), 32'(ea));
    chk("ula_b", 32'(ula_b), 32'(b));
    chk("ula_op", 32'(ula_op), 32'(op));
    chk("ready_exec", 32'(ready), 0);
    chk("valid_exec", 32'(valid), 0);
    if (noise) begin
      start = 1'b1; op_a = ~a; op_b = b + 8'd1; operacao = op ^ 3'b001; use_acc = ~ua;
    end
    for (int k = 2; k <= EC; k++) begin
      @(negedge clk);
      chk("valid_early", 32'(valid), 0);
    end
    if (clr_cap) clr_erro = 1'b1;
    @(negedge clk);
    clr_erro = 1'b0;
    start = 1'b0;
    acc_m = e[11:4];
    sticky_m = e[0] ? 1'b1 : (clr_cap ? 1'b0 : sticky_m);
    chk("valid_latency", 32'(valid), 1);
    chk("ready_done", 32'(ready), 0);
    chk("resultado", 32'(resultado), 32'(e[11:4]));
    chk("overflow", 32'(overflow), 32'(e[3]));
    chk("zero", 32'(zero), 32'(e[2]));
    chk("carry_out", 32'(carry_out), 32'(e[1]));
    chk("erro", 32'(erro), 32'(e[0]));
    chk("erro_sticky", 32'(erro_sticky), 32'(sticky_m));
    chk("ula_a_stable", 32'(ula_a), 32'(ea));
    repeat (hold) begin
      @(negedge clk);
      chk("valid_hold", 32'(valid), 1);
      chk("resultado_hold", 32'(resultado), 32'(e[11:4]));
    end
    ack = 1'b1;
    if (both) begin start = 1'b1; op_a = a + 8'd1; end
    @(negedge clk);
    ack = 1'b0; start = 1'b0;
    chk("valid_after_ack", 32'(valid), 0);
    chk("ready_after_ack", 32'(ready), 1);
    chk("resultado_kept", 32'(resultado), 32'(e[11:4]));
    @(negedge clk);
    chk("no_new_op", 32'(ready), 1);
  endtask

  initial begin
    #12;
    chk("rst_ready", 32'(ready), 1);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_resultado", 32'(resultado), 0);
    chk("rst_flags", 32'({overflow, zero, carry_out, erro, erro_sticky}), 0);
    chk("rst_ula_a", 32'(ula_a), 0);
    @(negedge clk);
    rst = 1'b1;
    run_op(8'd100, 8'd27, OP_SOMA, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("req028_res", 32'(resultado), 127);
    chk("req028_carry", 32'(carry_out), 0);
    chk("req028_zero", 32'(zero), 0);
    run_op(8'd200, 8'd100, OP_SOMA, 1'b0, 1, 1'b0, 1'b0, 1'b0);
    chk("req029_res", 32'(resultado), 44);
    chk("req029_carry", 32'(carry_out), 1);
    run_op(8'd77, 8'd6, OP_SOMA, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("req029_acc", 32'(resultado), 50);
    run_op(8'd9, 8'd0, OP_DIV, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    chk("req030_erro", 32'(erro), 1);
    chk("req030_sticky", 32'(erro_sticky), 1);
    clr_erro = 1'b1;
    @(negedge clk);
    clr_erro = 1'b0;
    sticky_m = 1'b0;
    chk("req030_clr", 32'(erro_sticky), 0);
    run_op(8'd5, 8'd0, OP_DIV, 1'b0, 0, 1'b0, 1'b0, 1'b1);
    chk("set_wins_clr", 32'(erro_sticky), 1);
    run_op(8'd12, 8'd3, OP_SUB, 1'b0, 0, 1'b1, 1'b0, 1'b0);
    chk("req031_res", 32'(resultado), 9);
    run_op(8'd20, 8'd4, OP_MULT, 1'b0, 5, 1'b0, 1'b1, 1'b0);
    chk("req033_res", 32'(resultado), 80);
    @(negedge clk);
    start = 1'b1; op_a = 8'd33; op_b = 8'd44; operacao = OP_XOR; use_acc = 1'b0;
    @(negedge clk);
    start = 1'b0;
    rst = 1'b0;
    #1;
    chk("req032_ready", 32'(ready), 1);
    chk("req032_valid", 32'(valid), 0);
    chk("req032_ula_a", 32'(ula_a), 0);
    chk("req032_sticky", 32'(erro_sticky), 0);
    @(negedge clk);
    rst = 1'b1;
    acc_m = '0;
    sticky_m = 1'b0;
    repeat (EC + 3) begin
      @(negedge clk);
      chk("req032_no_valid", 32'(valid), 0);
    end
    run_op(8'd99, 8'd5, OP_SOMA, 1'b1, 0, 1'b0, 1'b0, 1'b0);
    chk("req032_acc_zero", 32'(resultado), 5);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      run_op(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom), $urandom_range(0, 3),
             1'($urandom), 1'($urandom), $urandom_range(0, 5) == 0);
      if ($urandom_range(0, 3) == 0) begin
        clr_erro = 1'b1;
        @(negedge clk);
        clr_erro = 1'b0;
        sticky_m = 1'b0;
        chk("rand_clr", 32'(erro_sticky), 0);
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ula_sequenciador.md
ULA_SEQUENCIADOR -- requirements
Module: ula_sequenciador

Interface
REQ-001 SHALL have parameter EXEC_CYCLES, default 2, meaning ALU settle cycles per operation (legal 1..15).
REQ-002 SHALL have: clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have: rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have: start  input  1  request; sampled only when ready=1.
REQ-005 SHALL have: op_a, op_b  input  8 each  request operands.
REQ-006 SHALL have: operacao  input  3  request opcode.
REQ-007 SHALL have: use_acc  input  1  1 = replace op_a with accumulator.
REQ-008 SHALL have: ack  input  1  consumer accepts result.
REQ-009 SHALL have: clr_erro  input  1  clears erro_sticky.
REQ-010 SHALL have: ula_a, ula_b  output  8 each; ula_op  output  3  ALU drive.
REQ-011 SHALL have: ula_resultado  input  8; ula_overflow, ula_zero, ula_carry, ula_erro  input  1 each  ALU response.
REQ-012 SHALL have: ready  output  1; valid  output  1; resultado  output  8; overflow, zero, carry_out, erro  output  1 each; erro_sticky  output  1.

Function
REQ-013 SHALL implement FSM IDLE, EXEC, DONE; ready=1 only in IDLE, valid=1 only in DONE.
REQ-014 IDLE: start=1 at edge SHALL register operands (A = acc if use_acc else op_a), B, opcode; load counter EXEC_CYCLES-1; go EXEC.
REQ-015 ula_a/ula_b/ula_op SHALL be driven only from the operand registers, stable through EXEC and DONE.
REQ-016 EXEC: counter SHALL decrement each cycle; at edge with counter=0 SHALL capture ula_resultado and four flags into output registers, acc <= ula_resultado, go DONE.
REQ-017 Latency SHALL be EXEC_CYCLES+1 cycles from start edge to first valid=1 cycle.
REQ-018 DONE: outputs SHALL hold until ack=1 sampled; then go IDLE, valid=0 next cycle; result registers keep last value.
REQ-019 start while ready=0 SHALL be ignored (no queueing); ack while valid=0 SHALL be ignored.
REQ-020 start and ack both high in DONE: ack honoured, start ignored.
REQ-021 Captured ula_erro=1 SHALL still capture result; SHALL set erro_sticky.
REQ-022 erro_sticky SHALL clear on clr_erro=1; set wins if set and clear coincide.
REQ-023 Opcodes: 000 soma, 001 sub, 010 mult, 011 div, 100 and, 101 or, 110 xor, 111 not; controller SHALL pass opcode unmodified.

Reset
REQ-024 rst=0 SHALL immediately force IDLE, counter 0, operand/acc/result registers 0, all flags 0, valid=0, ready=1, erro_sticky=0.
REQ-025 Reset mid-EXEC or DONE SHALL abort; no result captured; acc 0.

Structure
REQ-026 Opcode constants and FSM state encodings SHALL live in shared package ula_pkg.
REQ-027 Down-counter MAY be sub-module contador_execucao; ALU SHALL be instantiated outside this block.

Verification
REQ-028 EXEC_CYCLES=2, op 000, A=100, B=27 -> valid at start+3, resultado=127, carry_out=0, zero=0.
REQ-029 op 000, A=200, B=100 -> resultado=44, carry_out=1; then use_acc=1, op 000, B=6 -> resultado=50.
REQ-030 op 011, A=9, B=0 -> erro=1, erro_sticky=1; clr_erro pulse -> erro_sticky=0.
REQ-031 start pulse while EXEC with different operands -> ignored; result matches first request.
REQ-032 rst=0 one cycle into EXEC -> ready=1, valid=0, acc=0 immediately; no valid pulse follows.
REQ-033 valid held 5 cycles without ack -> resultado stable; ack with start same cycle -> IDLE, no new op.
